fb_write_scheduler: RTL and testbench

Sequences and shares the single write port of the 320x240, 3-bit-per-pixel video framebuffer between two requesters: a single-pixel host port and a rectangle-fill engine. It also issues framebuffer flush strobes. It converts (x, y) coordinates to linear addresses (addr = y*320 + x) and clips anything off-screen. It sits between the board-level command logic and the video controller's addr/data/we/flush inputs.

---
 rtl/fb_write_scheduler_if.sv | 38 +++
 rtl/fb_write_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_fb_write_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_scheduler_if.sv
// Request and framebuffer-side signal bundle for fb_write_scheduler.
// The master side is the command logic; the slave side is the scheduler.
interface fb_write_scheduler_if;
    logic        px_valid;
    logic        px_ready;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [2:0]  px_color;
    logic        fill_start;
    logic [8:0]  fill_x0;
    logic [7:0]  fill_y0;
    logic [8:0]  fill_w;
    logic [7:0]  fill_h;
    logic [2:0]  fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        flush_req;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_flush;

    modport master (
        output px_valid, px_x, px_y, px_color,
        output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        output flush_req,
        input  px_ready, fill_busy, fill_done,
        input  fb_addr, fb_data, fb_we, fb_flush
    );

    modport slave (
        input  px_valid, px_x, px_y, px_color,
        input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
        input  flush_req,
        output px_ready, fill_busy, fill_done,
        output fb_addr, fb_data, fb_we, fb_flush
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Shares the 320x240x3 framebuffer write port between a pixel host port and a
// rectangle-fill engine, clips off-screen pixels and sequences flush strobes.
module fb_write_scheduler (
    input  logic                 clk,
    input  logic                 rst_n,
    fb_write_scheduler_if.slave  bus
);
    localparam logic [9:0] SCR_W = 10'd320;
    localparam logic [8:0] SCR_H = 9'd240;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        finish_s;

    logic [8:0]  x0_r;
    logic [8:0]  cur_x_r;
    logic [7:0]  cur_y_r;
    logic [9:0]  x_end_r;
    logic [8:0]  y_end_r;
    logic [2:0]  color_r;
    logic        fill_left_r;

    logic        flush_pend_r;
    logic        last_fill_r;
    logic [16:0] addr_r;
    logic [2:0]  data_r;
    logic        we_r;
    logic        flush_r;
    logic        busy_r;
    logic        done_r;

    logic [9:0]  x_sum_s;
    logic [9:0]  x_end_s;
    logic [8:0]  y_sum_s;
    logic [8:0]  y_end_s;
    logic        empty_s;
    logic        fill_req_s;
    logic        px_req_s;
    logic        px_win_s;
    logic        fill_win_s;
    logic        px_on_s;
    logic        x_wrap_s;
    logic        y_last_s;
    logic        last_px_s;
    logic        start_acc_s;
    logic        we_next_s;
    logic        flush_fire_s;

    // y*320 + x as y*256 + y*64 + x; result never exceeds 76799 for on-screen inputs.
    function automatic logic [16:0] lin_addr(input logic [8:0] x, input logic [7:0] y);
        lin_addr = {1'b0, y, 8'd0} + {3'b000, y, 6'd0} + {8'd0, x};
    endfunction

    // Clipped exclusive extents of the requested rectangle.
    assign x_sum_s = {1'b0, bus.fill_x0} + {1'b0, bus.fill_w};
    assign x_end_s = (x_sum_s > SCR_W) ? SCR_W : x_sum_s;
    assign y_sum_s = {1'b0, bus.fill_y0} + {1'b0, bus.fill_h};
    assign y_end_s = (y_sum_s > SCR_H) ? SCR_H : y_sum_s;
    assign empty_s = ({1'b0, bus.fill_x0} >= x_end_s) || ({1'b0, bus.fill_y0} >= y_end_s);

    assign fill_req_s  = (state_r == ST_RUN) && fill_left_r;
    assign px_req_s    = bus.px_valid && !flush_pend_r;
    assign px_win_s    = px_req_s && (!fill_req_s || last_fill_r);
    assign fill_win_s  = fill_req_s && !px_win_s;
    assign px_on_s     = (bus.px_x < 9'd320) && (bus.px_y < 8'd240);
    assign x_wrap_s    = (({1'b0, cur_x_r}) + 10'd1) == x_end_r;
    assign y_last_s    = (({1'b0, cur_y_r}) + 9'd1) == y_end_r;
    assign last_px_s   = fill_win_s && x_wrap_s && y_last_s;
    assign start_acc_s = (state_r == ST_IDLE) && bus.fill_start && !flush_pend_r;
    assign we_next_s   = fill_win_s || (px_win_s && px_on_s);

    // A flush only fires when the next cycle has the engine idle and no write on the port.
    assign flush_fire_s = (flush_pend_r || bus.flush_req) && (state_next_s == ST_IDLE) && !we_next_s;

    assign bus.px_ready  = rst_n & px_win_s;
    assign bus.fb_addr   = addr_r;
    assign bus.fb_data   = data_r;
    assign bus.fb_we     = we_r;
    assign bus.fb_flush  = flush_r;
    assign bus.fill_busy = busy_r;
    assign bus.fill_done = done_r;

    // Fill FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill FSM next state; an empty rectangle leaves RUN after a single cycle.
    always_comb begin
        state_next_s = state_r;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!fill_left_r || last_px_s) begin
                    state_next_s = ST_IDLE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                finish_s     = 1'b0;
            end
        endcase
    end

    // Command latch and row-major walker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_r        <= 9'd0;
            cur_x_r     <= 9'd0;
            cur_y_r     <= 8'd0;
            x_end_r     <= 10'd0;
            y_end_r     <= 9'd0;
            color_r     <= 3'd0;
            fill_left_r <= 1'b0;
        end else if (start_acc_s) begin
            x0_r        <= bus.fill_x0;
            cur_x_r     <= bus.fill_x0;
            cur_y_r     <= bus.fill_y0;
            x_end_r     <= x_end_s;
            y_end_r     <= y_end_s;
            color_r     <= bus.fill_color;
            fill_left_r <= !empty_s;
        end else if (fill_win_s) begin
            if (x_wrap_s) begin
                cur_x_r <= x0_r;
                cur_y_r <= cur_y_r + 8'd1;
                if (y_last_s) begin
                    fill_left_r <= 1'b0;
                end
            end else begin
                cur_x_r <= cur_x_r + 9'd1;
            end
        end
    end

    // Registered write port, status outputs, flush tracking and round-robin flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= 17'd0;
            data_r       <= 3'd0;
            we_r         <= 1'b0;
            flush_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            flush_pend_r <= 1'b0;
            last_fill_r  <= 1'b1;
        end else begin
            we_r <= we_next_s;
            if (fill_win_s) begin
                addr_r <= lin_addr(cur_x_r, cur_y_r);
                data_r <= color_r;
            end else if (px_win_s && px_on_s) begin
                addr_r <= lin_addr(bus.px_x, bus.px_y);
                data_r <= bus.px_color;
            end
            busy_r       <= (state_next_s == ST_RUN) || finish_s;
            done_r       <= finish_s;
            flush_r      <= flush_fire_s;
            flush_pend_r <= (flush_pend_r || bus.flush_req) && !flush_fire_s;
            if (px_win_s) begin
                last_fill_r <= 1'b0;
            end else if (fill_win_s) begin
                last_fill_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: directed tables and sequences plus
// random traffic compared every cycle against a queue-based reference model.
module tb_fb_write_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    fb_write_scheduler_if bus ();
    fb_write_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int x; int y; int c; int we; int addr; int data; } px_vec_t;
    typedef struct { int x0; int y0; int w; int h; int c; int first; int ncol; int nrow; } fill_vec_t;
    px_vec_t   pv[7];
    fill_vec_t fv[8];

    // reference model state: pending fill pixels as a queue of linear addresses
    int fq[$];
    bit m_run = 1'b0;
    bit m_pend = 1'b0;
    bit m_last_fill = 1'b1;
    int m_color = 0;
    int e_addr = 0;
    int e_data = 0;
    bit e_we = 1'b0;
    bit e_flush = 1'b0;
    bit e_busy = 1'b0;
    bit e_done = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic out_compare();
        chk("m_fb_we", bus.fb_we, e_we);
        chk("m_fb_addr", bus.fb_addr, e_addr);
        chk("m_fb_data", bus.fb_data, e_data);
        chk("m_fb_flush", bus.fb_flush, e_flush);
        chk("m_fill_busy", bus.fill_busy, e_busy);
        chk("m_fill_done", bus.fill_done, e_done);
    endtask

    task automatic model_step();
        bit fill_has, px_req, px_win, fill_win, fin, n_run, n_we, n_flush, pend;
        fill_has = m_run && (fq.size() > 0);
        px_req   = bus.px_valid && !m_pend;
        px_win   = px_req && (!fill_has || m_last_fill);
        fill_win = fill_has && !px_win;
        chk("m_px_ready", bus.px_ready, px_win);
        n_we = 1'b0;
        if (px_win) begin
            m_last_fill = 1'b0;
            if (bus.px_x < 320 && bus.px_y < 240) begin
                n_we   = 1'b1;
                e_addr = bus.px_y * 320 + bus.px_x;
                e_data = bus.px_color;
            end
        end else if (fill_win) begin
            m_last_fill = 1'b1;
            n_we   = 1'b1;
            e_addr = fq.pop_front();
            e_data = m_color;
        end
        fin   = m_run && (fq.size() == 0);
        n_run = m_run && !fin;
        if (!m_run && bus.fill_start && !m_pend) begin
            for (int y = bus.fill_y0; y < bus.fill_y0 + bus.fill_h && y < 240; y++)
                for (int x = bus.fill_x0; x < bus.fill_x0 + bus.fill_w && x < 320; x++)
                    fq.push_back(y * 320 + x);
            m_color = bus.fill_color;
            n_run   = 1'b1;
        end
        pend    = m_pend || bus.flush_req;
        n_flush = pend && !n_run && !n_we;
        m_pend  = pend && !n_flush;
        m_run   = n_run;
        e_we    = n_we;
        e_flush = n_flush;
        e_busy  = n_run || fin;
        e_done  = fin;
    endtask

    // model checker, sampling 3 time units after each falling edge
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            fq.delete();
            m_run = 1'b0; m_pend = 1'b0; m_last_fill = 1'b1;
            e_addr = 0; e_data = 0; e_we = 1'b0; e_flush = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            out_compare();
            chk("m_rst_ready", bus.px_ready, 0);
        end else begin
            out_compare();
            model_step();
        end
    end

    task automatic idle_in();
        bus.px_valid = 1'b0; bus.px_x = 9'd0; bus.px_y = 8'd0; bus.px_color = 3'd0;
        bus.fill_start = 1'b0; bus.fill_x0 = 9'd0; bus.fill_y0 = 8'd0;
        bus.fill_w = 9'd0; bus.fill_h = 8'd0; bus.fill_color = 3'd0;
        bus.flush_req = 1'b0;
    endtask

    task automatic set_px(input int x, input int y, input int c);
        bus.px_valid = 1'b1; bus.px_x = 9'(x); bus.px_y = 8'(y); bus.px_color = 3'(c);
    endtask

    task automatic fill_cmd(input int x0, input int y0, input int w, input int h, input int c);
        bus.fill_start = 1'b1; bus.fill_x0 = 9'(x0); bus.fill_y0 = 8'(y0);
        bus.fill_w = 9'(w); bus.fill_h = 8'(h); bus.fill_color = 3'(c);
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_we"}, bus.fb_we, 0);
        chk({tag, "_addr"}, bus.fb_addr, 0);
        chk({tag, "_data"}, bus.fb_data, 0);
        chk({tag, "_flush"}, bus.fb_flush, 0);
        chk({tag, "_busy"}, bus.fill_busy, 0);
        chk({tag, "_done"}, bus.fill_done, 0);
        chk({tag, "_ready"}, bus.px_ready, 0);
    endtask

    // uncontended fill: writes at N+2..N+P+1, done with last write (N+2 if empty)
    task automatic run_fill(input fill_vec_t v);
        int p, dk, wi;
        p  = v.ncol * v.nrow;
        dk = (p + 1 > 2) ? p + 1 : 2;
        wi = 0;
        @(negedge clk);
        fill_cmd(v.x0, v.y0, v.w, v.h, v.c);
        @(negedge clk);
        bus.fill_start = 1'b0;
        for (int k = 1; k <= dk + 2; k++) begin
            if (k > 1) @(negedge clk);
            #2;
            chk("fill_busy", bus.fill_busy, (k <= dk));
            chk("fill_done", bus.fill_done, (k == dk));
            chk("fill_we", bus.fb_we, (k >= 2 && k <= p + 1));
            if (k >= 2 && k <= p + 1) begin
                chk("fill_addr", bus.fb_addr, v.first + (wi / v.ncol) * 320 + (wi % v.ncol));
                chk("fill_data", bus.fb_data, v.c);
                wi++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        int pi;
        bit r;
        pv[0] = '{5, 2, 7, 1, 645, 7};
        pv[1] = '{0, 0, 1, 1, 0, 1};
        pv[2] = '{319, 239, 3, 1, 76799, 3};
        pv[3] = '{320, 0, 5, 0, 76799, 3};
        pv[4] = '{0, 240, 6, 0, 76799, 3};
        pv[5] = '{100, 17, 2, 1, 5540, 2};
        pv[6] = '{511, 255, 4, 0, 5540, 2};
        fv[0] = '{10, 1, 3, 2, 5, 330, 3, 2};
        fv[1] = '{318, 239, 4, 3, 6, 76798, 2, 1};
        fv[2] = '{0, 0, 0, 5, 1, 0, 0, 0};
        fv[3] = '{320, 0, 4, 4, 1, 0, 0, 0};
        fv[4] = '{7, 239, 2, 9, 3, 76487, 2, 1};
        fv[5] = '{319, 0, 1, 3, 7, 319, 1, 3};
        fv[6] = '{300, 230, 50, 50, 2, 73900, 20, 10};
        fv[7] = '{5, 5, 3, 0, 4, 0, 0, 0};

        idle_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        bus.px_valid = 1'b1;
        #2;
        zero_check("reset");
        @(negedge clk);
        bus.px_valid = 1'b0;
        rst_n = 1'b1;

        // single-pixel writes, on- and off-screen
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_px(pv[i].x, pv[i].y, pv[i].c);
            #1;
            chk("px_ready", bus.px_ready, 1);
            @(negedge clk);
            bus.px_valid = 1'b0;
            #2;
            chk("px_we", bus.fb_we, pv[i].we);
            chk("px_addr", bus.fb_addr, pv[i].addr);
            chk("px_data", bus.fb_data, pv[i].data);
        end

        for (int i = 0; i < 8; i++) run_fill(fv[i]);

        // contention: pixel port held busy while a 4-pixel fill runs
        @(negedge clk);
        fill_cmd(20, 3, 4, 1, 2);
        set_px(100, 50, 1);
        pi = 0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                bus.fill_start = 1'b0;
                if (pi < 4) set_px(100 + pi, 50, 1);
                else bus.px_valid = 1'b0;
            end
            #1;
            r = bus.px_ready;
            chk("cont_ready", r, (k < 8 && k % 2 == 0));
            if (r) pi++;
            #1;
            chk("cont_we", bus.fb_we, (k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) begin
                if (k % 2 == 1) begin
                    chk("cont_px_addr", bus.fb_addr, 16100 + (k - 1) / 2);
                    chk("cont_px_data", bus.fb_data, 1);
                end else begin
                    chk("cont_fill_addr", bus.fb_addr, 980 + k / 2 - 1);
                    chk("cont_fill_data", bus.fb_data, 2);
                end
            end
            chk("cont_done", bus.fill_done, (k == 8));
        end

        // flush requested mid-fill waits for the fill, blocks pixels and new starts
        @(negedge clk);
        fill_cmd(40, 10, 6, 1, 3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 7) fill_cmd(0, 0, 2, 2, 7);
            else bus.fill_start = 1'b0;
            bus.flush_req = (k == 2);
            if (k == 3) set_px(1, 1, 6);
            if (k == 9) bus.px_valid = 1'b0;
            #1;
            chk("fl_ready", bus.px_ready, (k == 8));
            #1;
            chk("fl_flush", bus.fb_flush, (k == 8));
            chk("fl_we", bus.fb_we, ((k >= 2 && k <= 7) || k == 9));
            if (k >= 2 && k <= 7) chk("fl_fill_addr", bus.fb_addr, 3240 + k - 2);
            if (k == 9) chk("fl_px_addr", bus.fb_addr, 321);
            chk("fl_done", bus.fill_done, (k == 7));
        end

        // flush while idle: strobe one cycle after the request
        @(negedge clk);
        bus.flush_req = 1'b1;
        #2;
        chk("idle_flush_n", bus.fb_flush, 0);
        @(negedge clk);
        bus.flush_req = 1'b0;
        #2;
        chk("idle_flush_n1", bus.fb_flush, 1);
        @(negedge clk);
        #2;
        chk("idle_flush_n2", bus.fb_flush, 0);

        // reset asserted during the 3rd write of a 10-pixel fill
        @(negedge clk);
        fill_cmd(0, 100, 10, 1, 4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.fill_start = 1'b0;
            if (k == 4) begin
                rst_n = 1'b0;
                set_px(2, 2, 1);
                #1;
                zero_check("midrst");
            end else begin
                #2;
                chk("midrst_we", bus.fb_we, (k >= 2));
            end
        end
        @(negedge clk);
        bus.px_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            #2;
            chk("post_rst_we", bus.fb_we, 0);
            chk("post_rst_done", bus.fill_done, 0);
            chk("post_rst_busy", bus.fill_busy, 0);
        end
        run_fill(fv[0]);

        // random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.px_valid   = ($urandom_range(0, 1) == 1);
            bus.px_x       = 9'($urandom_range(0, 330));
            bus.px_y       = 8'($urandom_range(0, 250));
            bus.px_color   = 3'($urandom_range(0, 7));
            bus.fill_start = ($urandom_range(0, 19) == 0);
            bus.fill_x0    = 9'($urandom_range(0, 325));
            bus.fill_y0    = 8'($urandom_range(0, 245));
            bus.fill_w     = 9'($urandom_range(0, 8));
            bus.fill_h     = 8'($urandom_range(0, 4));
            bus.fill_color = 3'($urandom_range(0, 7));
            bus.flush_req  = ($urandom_range(0, 29) == 0);
            rst_n          = !($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
